// File: rtl/lod_norm_pipe.sv
// lod_norm_pipe: two-stage stallable leading/trailing-one detector with normaliser
module lod_norm_pipe #(
    parameter int WIDTH = 9,
    localparam int IDX_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_trail,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_index,
    output logic             out_zero,
    output logic [WIDTH-1:0] out_norm,
    output logic             out_trail
);
    logic             s1_valid, s1_trail, s1_zero, s2_adv;
    logic [WIDTH-1:0] s1_data, s1_norm;
    logic [IDX_W-1:0] s1_idx, sh;

    // Later matches overwrite earlier ones, so scan direction picks the priority end.
    always_comb begin
        s1_idx = '1;
        if (s1_trail) begin
            for (int i = WIDTH - 1; i >= 0; i--)
                if (s1_data[i]) s1_idx = IDX_W'(i);
        end else begin
            for (int i = 0; i < WIDTH; i++)
                if (s1_data[i]) s1_idx = IDX_W'(i);
        end
    end

    assign s1_zero  = ~|s1_data;
    assign sh       = s1_trail ? s1_idx : IDX_W'(WIDTH - 1) - s1_idx;
    assign s1_norm  = s1_zero ? '0 : s1_trail ? s1_data >> sh : s1_data << sh;
    assign s2_adv   = ~out_valid | out_ready;
    assign in_ready = ~s1_valid | s2_adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_data   <= '0;
            s1_trail  <= 1'b0;
            out_valid <= 1'b0;
            out_index <= '0;
            out_zero  <= 1'b0;
            out_norm  <= '0;
            out_trail <= 1'b0;
        end else begin
            if (in_ready) s1_valid <= in_valid;
            if (in_valid && in_ready) begin
                s1_data  <= in_data;
                s1_trail <= in_trail;
            end
            if (s2_adv) out_valid <= s1_valid;
            if (s1_valid && s2_adv) begin
                out_index <= s1_idx;
                out_zero  <= s1_zero;
                out_norm  <= s1_norm;
                out_trail <= s1_trail;
            end
        end
    end
endmodule

// File: tb/tb_lod_norm_pipe.sv
// tb_lod_norm_pipe: directed and randomised checks of lod_norm_pipe against a reference model
module tb_lod_norm_pipe;
    localparam int W = 9;
    localparam int IW = 5;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          in_valid = 1'b0, in_trail = 1'b0, out_ready = 1'b1;
    logic          in_ready, out_valid, out_zero, out_trail;
    logic [W-1:0]  in_data = '0, out_norm;
    logic [IW-1:0] out_index;
    int            n_chk = 0, n_fail = 0;
    logic [15:0]   q[$];

    lod_norm_pipe #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_trail(in_trail), .out_valid(out_valid),
        .out_ready(out_ready), .out_index(out_index), .out_zero(out_zero),
        .out_norm(out_norm), .out_trail(out_trail)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Packed result {trail, index, zero, norm}; leading scan stops at the first one from the top.
    function automatic logic [15:0] model(input logic [W-1:0] d, input logic t);
        int p = -1;
        logic [W-1:0] n;
        if (t) begin
            for (int i = 0; i < W; i++) if (d[i] && p < 0) p = i;
        end else begin
            for (int i = W - 1; i >= 0; i--) if (d[i] && p < 0) p = i;
        end
        n = (p < 0) ? '0 : t ? d >> p : d << (W - 1 - p);
        return {t, IW'(p), p < 0, n};
    endfunction

    function automatic logic [15:0] obs();
        return {out_trail, out_index, out_zero, out_norm};
    endfunction

    task automatic directed(input string tag, input logic [W-1:0] d, input logic t,
                            input logic [IW-1:0] ei, input logic ez, input logic [W-1:0] en);
        in_valid = 1'b1; in_data = d; in_trail = t;
        tick;
        in_valid = 1'b0;
        chk({tag, "_lat1"}, out_valid, 1'b0);
        tick;
        chk({tag, "_valid"}, out_valid, 1'b1);
        chk({tag, "_res"}, obs(), {t, ei, ez, en});
    endtask

    // Pushes accepted beats into the scoreboard and pops on every output transfer.
    task automatic run(input string tag, input int n, input bit rnd);
        int sent = 0, rx = 0, cyc = 0;
        bit xfer;
        in_valid = 1'b0;
        while (rx < n && cyc < 2000) begin
            xfer = 1'b0;
            if (!in_valid && sent < n && (!rnd || $urandom_range(3) != 0)) begin
                in_valid = 1'b1;
                in_data  = W'($urandom_range(511));
                in_trail = 1'($urandom_range(1));
            end
            out_ready = rnd ? 1'($urandom_range(1)) : 1'b1;
            #1;
            if (out_valid && out_ready) begin
                if (q.size() == 0) chk({tag, "_extra"}, obs(), 16'hxxxx);
                else chk({tag, "_beat"}, obs(), q.pop_front());
                rx++;
            end
            if (in_valid && in_ready) begin
                q.push_back(model(in_data, in_trail));
                sent++;
                xfer = 1'b1;
            end
            @(posedge clk);
            #1;
            if (xfer) in_valid = 1'b0;
            cyc++;
        end
        chk({tag, "_count"}, rx, n);
        chk({tag, "_left"}, q.size(), 0);
        if (!rnd) chk({tag, "_cycles"}, cyc, n + 2);
        out_ready = 1'b1;
    endtask

    initial begin
        int hold_bad;
        #12;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_res", obs(), 16'h0000);
        rst_n = 1'b1;
        tick;
        chk("rst_ready", in_ready, 1'b1);

        directed("lead_050", 9'h050, 1'b0, 5'd6, 1'b0, 9'h140);
        directed("trail_050", 9'h050, 1'b1, 5'd4, 1'b0, 9'h005);
        directed("zero_lead", 9'h000, 1'b0, 5'h1f, 1'b1, 9'h000);
        directed("zero_trail", 9'h000, 1'b1, 5'h1f, 1'b1, 9'h000);
        directed("lead_100", 9'h100, 1'b0, 5'd8, 1'b0, 9'h100);
        directed("trail_100", 9'h100, 1'b1, 5'd8, 1'b0, 9'h001);
        directed("lead_001", 9'h001, 1'b0, 5'd0, 1'b0, 9'h100);
        directed("trail_001", 9'h001, 1'b1, 5'd0, 1'b0, 9'h001);
        directed("lead_1ff", 9'h1ff, 1'b0, 5'd8, 1'b0, 9'h1ff);
        directed("trail_1ff", 9'h1ff, 1'b1, 5'd0, 1'b0, 9'h1ff);
        tick;

        // Backpressure: A and B fill the pipe, C must wait.
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 9'h0a0; in_trail = 1'b0;
        tick;
        in_data = 9'h003; in_trail = 1'b1;
        tick;
        in_data = 9'h180; in_trail = 1'b0;
        chk("bp_ready_low", in_ready, 1'b0);
        chk("bp_hold_a", obs(), {1'b0, 5'd7, 1'b0, 9'h140});
        hold_bad = 0;
        for (int i = 0; i < 3; i++) begin
            tick;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || obs() !== {1'b0, 5'd7, 1'b0, 9'h140}) hold_bad++;
        end
        chk("bp_stall_hold", hold_bad, 0);
        out_ready = 1'b1;
        #1;
        chk("bp_ready_up", in_ready, 1'b1);
        tick;
        in_valid = 1'b0;
        chk("bp_out_b", obs(), {1'b1, 5'd0, 1'b0, 9'h003});
        tick;
        chk("bp_out_c", obs(), {1'b0, 5'd8, 1'b0, 9'h180});
        chk("bp_c_valid", out_valid, 1'b1);
        tick;
        chk("bp_drained", out_valid, 1'b0);

        run("stream", 64, 1'b0);
        run("rnd", 60, 1'b1);
        tick;

        // Reset with both stages full must drop everything at once.
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 9'h011; in_trail = 1'b0;
        tick;
        in_data = 9'h022;
        tick;
        in_valid = 1'b0;
        chk("mid_full", {out_valid, in_ready}, 2'b10);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_async", out_valid, 1'b0);
        tick;
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick;
        chk("mid_ready", in_ready, 1'b1);
        hold_bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (out_valid !== 1'b0) hold_bad++;
            tick;
        end
        chk("mid_no_stale", hold_bad, 0);
        directed("post_rst", 9'h024, 1'b1, 5'd2, 1'b0, 9'h009);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
